// File: rtl/lut_loader.sv
// ---------------------------------------------------------------------------
// lut_loader: unpacks a stream of 32-bit words into 24-bit LUT entries and
// writes them to table addresses 0..NUM_ENTRIES-1.            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lut_loader #(
  parameter int NUM_ENTRIES = 19,
  parameter int ENTRY_W     = 24,
  parameter int ADDR_W      = 5,
  parameter int WORD_W      = 32
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ENTRY_W-1:0] datain,
  output logic              we,
  output logic              busy,
  output logic              done
);

  localparam int WORDS_NEEDED = (NUM_ENTRIES * ENTRY_W + WORD_W - 1) / WORD_W;
  localparam int BUF_W        = 2 * WORD_W;
  localparam int FILL_W       = $clog2(BUF_W + 1);
  localparam int WCNT_W       = $clog2(WORDS_NEEDED + 1);
  localparam int ECNT_W       = $clog2(NUM_ENTRIES + 1);

  localparam logic [FILL_W-1:0] FILL_ENTRY = FILL_W'(ENTRY_W);
  localparam logic [FILL_W-1:0] FILL_WORD  = FILL_W'(WORD_W);
  localparam logic [WCNT_W-1:0] WORDS_ALL  = WCNT_W'(WORDS_NEEDED);
  localparam logic [ECNT_W-1:0] ENTRIES    = ECNT_W'(NUM_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BUF_W-1:0]    bitbuf_q, bitbuf_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ECNT_W-1:0]   entry_cnt_q, entry_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [ENTRY_W-1:0]  datain_q, datain_d;

  logic                emit;
  logic                accept;
  logic [BUF_W-1:0]    bitbuf_shift;
  logic [FILL_W-1:0]   fill_base;

  assign in_ready = (state_q == LOAD) && (fill_q <= FILL_WORD) && (word_cnt_q < WORDS_ALL);
  assign accept   = in_valid && in_ready;
  assign emit     = (state_q == LOAD) && (fill_q >= FILL_ENTRY) && (entry_cnt_q < ENTRIES);

  // When an entry leaves this cycle, the incoming word lands at the post-shift position.
  assign bitbuf_shift = emit ? (bitbuf_q >> ENTRY_W) : bitbuf_q;
  assign fill_base    = emit ? (fill_q - FILL_ENTRY) : fill_q;

  always_comb begin
    state_d     = state_q;
    bitbuf_d    = bitbuf_q;
    fill_d      = fill_q;
    word_cnt_d  = word_cnt_q;
    entry_cnt_d = entry_cnt_q;
    we_d        = 1'b0;
    w_addr_d    = w_addr_q;
    datain_d    = datain_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bitbuf_d    = '0;
          fill_d      = '0;
          word_cnt_d  = '0;
          entry_cnt_d = '0;
        end
      end
      LOAD: begin
        if (emit) begin
          we_d        = 1'b1;
          w_addr_d    = ADDR_W'(entry_cnt_q);
          datain_d    = bitbuf_q[ENTRY_W-1:0];
          entry_cnt_d = entry_cnt_q + 1'b1;
        end
        if (accept) begin
          bitbuf_d   = bitbuf_shift | (BUF_W'(in_data) << fill_base);
          fill_d     = fill_base + FILL_WORD;
          word_cnt_d = word_cnt_q + 1'b1;
        end else begin
          bitbuf_d   = bitbuf_shift;
          fill_d     = fill_base;
        end
        // Leave only once the final write has been registered onto the port.
        if (entry_cnt_q == ENTRIES) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q     <= IDLE;
      bitbuf_q    <= '0;
      fill_q      <= '0;
      word_cnt_q  <= '0;
      entry_cnt_q <= '0;
      we_q        <= 1'b0;
      w_addr_q    <= '0;
      datain_q    <= '0;
    end else begin
      state_q     <= state_d;
      bitbuf_q    <= bitbuf_d;
      fill_q      <= fill_d;
      word_cnt_q  <= word_cnt_d;
      entry_cnt_q <= entry_cnt_d;
      we_q        <= we_d;
      w_addr_q    <= w_addr_d;
      datain_q    <= datain_d;
    end
  end

  assign we     = we_q;
  assign w_addr = w_addr_q;
  assign datain = datain_q;
  assign busy   = (state_q == LOAD);
  assign done   = (state_q == DONE);

endmodule

`default_nettype wire
